// File: rtl/traffic_pkg.sv
// ============================================================================
// Module : traffic_pkg
// Brief  : Phase/error types, lamp patterns and sequence helper for the
//          junction traffic-light monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

   typedef enum logic [2:0] {
      SYNC       = 3'd0,
      RED        = 3'd1,
      RED_ORANGE = 3'd2,
      GREEN      = 3'd3,
      ORANGE     = 3'd4
   } phase_t;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      ILLEGAL = 2'd1,
      SEQ     = 2'd2,
      DWELL   = 2'd3
   } err_t;

   // Lamp patterns ordered {red, orange, green}
   localparam logic [2:0] LAMP_RED        = 3'b100;
   localparam logic [2:0] LAMP_RED_ORANGE = 3'b110;
   localparam logic [2:0] LAMP_GREEN      = 3'b001;
   localparam logic [2:0] LAMP_ORANGE     = 3'b010;

   function automatic phase_t successor(input phase_t p);
      phase_t s;
      case (p)
         RED:        s = RED_ORANGE;
         RED_ORANGE: s = GREEN;
         GREEN:      s = ORANGE;
         ORANGE:     s = RED;
         default:    s = RED;
      endcase
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_if.sv
// ============================================================================
// Module : traffic_if
// Brief  : Lamp inputs and monitor status bundle; slave = monitor side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface traffic_if
   import traffic_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int CYC_W = 16
);
   logic             red;
   logic             orange;
   logic             green;
   phase_t           phase;
   logic [CNT_W-1:0] dwell;
   logic [CYC_W-1:0] cycle_count;
   logic             go;
   logic             err;
   err_t             err_code;

   modport master (
      output red, orange, green,
      input  phase, dwell, cycle_count, go, err, err_code
   );

   modport slave (
      input  red, orange, green,
      output phase, dwell, cycle_count, go, err, err_code
   );
endinterface

`default_nettype wire

// File: rtl/traffic_decode.sv
// ============================================================================
// Module : traffic_decode
// Brief  : Combinational lamp-pattern decoder to phase_t plus illegal flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_decode
   import traffic_pkg::*;
(
   input  logic       red,
   input  logic       orange,
   input  logic       green,
   output phase_t     pattern,
   output logic       illegal
);
   always_comb begin
      pattern = SYNC;
      illegal = 1'b0;
      case ({red, orange, green})
         LAMP_RED:        pattern = RED;
         LAMP_RED_ORANGE: pattern = RED_ORANGE;
         LAMP_GREEN:      pattern = GREEN;
         LAMP_ORANGE:     pattern = ORANGE;
         default:         illegal = 1'b1;
      endcase
   end
endmodule

`default_nettype wire

// File: rtl/traffic_monitor.sv
// ============================================================================
// Module : traffic_monitor
// Brief  : Passive sequence/dwell checker on the traffic-light lamp outputs.
//          Option macro TRAFFIC_MON_STICKY_EN: err held from first error.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_monitor
   import traffic_pkg::*;
#(
   parameter int MIN_DWELL = 1,
   parameter int MAX_DWELL = 4,
   parameter int CNT_W     = 8,
   parameter int CYC_W     = 16
)(
   input  wire logic  clk,
   input  wire logic  reset,
   traffic_if.slave   mon
);
   phase_t pattern;
   logic   illegal;
   err_t   event_err;
   phase_t next_phase;

   traffic_decode u_decode (
      .red     (mon.red),
      .orange  (mon.orange),
      .green   (mon.green),
      .pattern (pattern),
      .illegal (illegal)
   );

   // Classify this sample; at most one error class can apply
   always_comb begin
      event_err = NONE;
      if (illegal)
         event_err = ILLEGAL;
      else if (mon.phase == SYNC)
         event_err = NONE;
      else if (pattern == mon.phase) begin
         if (mon.dwell == CNT_W'(MAX_DWELL))
            event_err = DWELL;
      end else if (pattern == successor(mon.phase)) begin
         if (mon.dwell < CNT_W'(MIN_DWELL))
            event_err = DWELL;
      end else
         event_err = SEQ;
   end

   always_comb begin
      next_phase = mon.phase;
      if (event_err != NONE)
         next_phase = SYNC;
      else if (mon.phase == SYNC) begin
         if (pattern == RED)
            next_phase = RED;
      end else if (pattern == successor(mon.phase))
         next_phase = pattern;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mon.phase       <= SYNC;
         mon.dwell       <= '0;
         mon.cycle_count <= '0;
         mon.go          <= 1'b0;
         mon.err         <= 1'b0;
         mon.err_code    <= NONE;
      end else begin
         mon.phase <= next_phase;
         mon.go    <= (next_phase == GREEN);

         if (event_err != NONE)
            mon.dwell <= '0;
         else if (next_phase == SYNC)
            mon.dwell <= '0;
         else if (next_phase != mon.phase)
            mon.dwell <= CNT_W'(1);
         else if (mon.dwell != '1)
            mon.dwell <= mon.dwell + CNT_W'(1);

         if (event_err == NONE && mon.phase == ORANGE && pattern == RED)
            mon.cycle_count <= mon.cycle_count + CYC_W'(1);

`ifdef TRAFFIC_MON_STICKY_EN
         mon.err <= mon.err | (event_err != NONE);
         if (event_err != NONE && mon.err_code == NONE)
            mon.err_code <= event_err;
`else
         mon.err <= (event_err != NONE);
         if (event_err != NONE)
            mon.err_code <= event_err;
`endif
      end
   end
endmodule

`default_nettype wire
